// File: rtl/cpu_phase_sequencer_if.sv
// rtl/cpu_phase_sequencer_if.sv - control/status bundle between board controls, core and phase sequencer
//
// master: board/core side, drives the controls and observes the phase outputs.
// slave : cpu_phase_sequencer.
//   div_load, div_value        divisor load strobe and value (0 means 1)
//   run, halt, step, halt_req  execution control requests
//   phase, phase_en            current phase and its enable for the core
//   running, instr_count       sequencer status

interface cpu_phase_sequencer_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 run;
  logic                 halt;
  logic                 step;
  logic                 halt_req;
  logic [1:0]           phase;
  logic                 phase_en;
  logic                 running;
  logic [31:0]          instr_count;

  modport master (
    output div_load, div_value, run, halt, step, halt_req,
    input  phase, phase_en, running, instr_count
  );

  modport slave (
    input  div_load, div_value, run, halt, step, halt_req,
    output phase, phase_en, running, instr_count
  );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - FETCH/DECODE/EXECUTE/WRITEBACK sequencer with clock-enable divider and run/halt/step
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    cpu_phase_sequencer_if.slave (controls in, phase/phase_en/running/instr_count out)

module cpu_phase_sequencer #(
  parameter int DIV_WIDTH     = 16,
  parameter int DEFAULT_DIV   = 50000,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_phase_sequencer_if.slave   bus
);

  localparam logic [DIV_WIDTH-1:0] RESET_DIV =
    (DEFAULT_DIV < 1) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

  localparam logic [1:0] PH_FETCH     = 2'd0;
  localparam logic [1:0] PH_WRITEBACK = 2'd3;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  localparam state_t RESET_STATE = START_RUNNING ? RUNNING : HALTED;

  state_t               state;
  logic [1:0]           phase;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] counter;
  logic                 pending;
  logic [31:0]          instr_count;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 tick;
  logic                 wb_tick;
  logic                 fetch_idle;
  logic                 halt_any;

  assign div_eff    = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  assign tick       = (state != HALTED) && (counter == div_eff - DIV_WIDTH'(1));
  assign wb_tick    = tick && (phase == PH_WRITEBACK);
  // No FETCH issued yet for the current instruction, so halting here loses nothing.
  assign fetch_idle = (phase == PH_FETCH) && !tick;
  assign halt_any   = bus.halt | bus.halt_req;

  assign bus.phase       = phase;
  assign bus.phase_en    = tick;
  assign bus.running     = (state != HALTED);
  assign bus.instr_count = instr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RESET_STATE;
      phase       <= PH_FETCH;
      divisor     <= RESET_DIV;
      counter     <= '0;
      pending     <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      if (bus.div_load) begin
        divisor <= bus.div_value;
      end
      if (tick) begin
        phase <= phase + 2'd1;
      end
      if (wb_tick) begin
        instr_count <= instr_count + 32'd1;
      end

      // Counter idles at 0 while halted, so the first tick lands div_eff
      // cycles after the start is accepted.
      if ((state == HALTED) || bus.div_load || tick) begin
        counter <= '0;
      end else begin
        counter <= counter + DIV_WIDTH'(1);
      end

      case (state)
        HALTED: begin
          pending <= 1'b0;
          if (!halt_any) begin
            if (bus.run) begin
              state <= RUNNING;
            end else if (bus.step) begin
              state <= STEPPING;
            end
          end
        end
        RUNNING: begin
          if ((pending || halt_any) && (fetch_idle || wb_tick)) begin
            state   <= HALTED;
            pending <= 1'b0;
            counter <= '0;
          end else begin
            pending <= pending | halt_any;
          end
        end
        STEPPING: begin
          if (wb_tick) begin
            state <= HALTED;
          end
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule
